// File: rtl/etapa_id.sv
// Decode stage of the vector pipeline: IF/ID latch, vector register file with
// write-first bypass, load-use hazard detection and the RUN/HALTED control FSM.
module etapa_id #(
    parameter int unsigned VEC_W    = 32,
    parameter int unsigned NUM_VREG = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [13:0]      instruccion,
    input  logic             flush,
    input  logic             ex_load,
    input  logic [1:0]       ex_rd,
    input  logic             wb_we,
    input  logic [1:0]       wb_addr,
    input  logic [VEC_W-1:0] wb_data,
    output logic             stall,
    output logic             halted,
    output logic             id_valid,
    output logic [3:0]       id_opcode,
    output logic [1:0]       id_vd,
    output logic [VEC_W-1:0] id_vs1_data,
    output logic [VEC_W-1:0] id_vs2_data,
    output logic [3:0]       id_imm,
    output logic             id_we
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_XOR  = 4'h1;
    localparam logic [3:0] OP_SHL  = 4'h2;
    localparam logic [3:0] OP_SHR  = 4'h3;
    localparam logic [3:0] OP_ROL  = 4'h4;
    localparam logic [3:0] OP_ROR  = 4'h5;
    localparam logic [3:0] OP_ADD  = 4'h6;
    localparam logic [3:0] OP_SUB  = 4'h7;
    localparam logic [3:0] OP_LDV  = 4'h8;
    localparam logic [3:0] OP_STV  = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [0:0] {RUN, HALTED} state_t;

    state_t           state;
    logic [13:0]      ifid_instr;
    logic             ifid_valid;
    logic [VEC_W-1:0] vreg [NUM_VREG];

    logic [3:0]       f_op;
    logic [1:0]       f_vd;
    logic [1:0]       f_vs1;
    logic [1:0]       f_vs2;
    logic [3:0]       f_imm;

    logic [3:0]       dec_op;
    logic             uses_vs1;
    logic             uses_vs2;
    logic             dec_we;
    logic             hazard;
    logic             issue;
    logic [VEC_W-1:0] rd1;
    logic [VEC_W-1:0] rd2;

    assign f_op  = ifid_instr[13:10];
    assign f_vd  = ifid_instr[9:8];
    assign f_vs1 = ifid_instr[7:6];
    assign f_vs2 = ifid_instr[5:4];
    assign f_imm = ifid_instr[3:0];

    // Opcode decode: operand usage and write-enable; unknown opcodes become NOP
    always_comb begin
        dec_op   = f_op;
        uses_vs1 = 1'b0;
        uses_vs2 = 1'b0;
        dec_we   = 1'b0;
        case (f_op)
            OP_XOR, OP_ADD, OP_SUB: begin
                uses_vs1 = 1'b1;
                uses_vs2 = 1'b1;
                dec_we   = 1'b1;
            end
            OP_SHL, OP_SHR, OP_ROL, OP_ROR: begin
                uses_vs1 = 1'b1;
                dec_we   = 1'b1;
            end
            OP_LDV:  dec_we   = 1'b1;
            OP_STV:  uses_vs1 = 1'b1;
            OP_NOP, OP_HALT: ;
            default: dec_op   = OP_NOP;
        endcase
    end

    assign hazard = ifid_valid && ex_load &&
                    ((uses_vs1 && (ex_rd == f_vs1)) || (uses_vs2 && (ex_rd == f_vs2)));

    // Flush squashes the hazard; HALTED freezes fetch; reset forces it low
    assign stall  = reset_n && ((state == HALTED) || (!flush && hazard));
    assign issue  = (state == RUN) && !flush && !hazard && ifid_valid;
    assign halted = (state == HALTED);

    // Write-first read ports
    assign rd1 = (wb_we && (wb_addr == f_vs1)) ? wb_data : vreg[f_vs1];
    assign rd2 = (wb_we && (wb_addr == f_vs2)) ? wb_data : vreg[f_vs2];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= RUN;
            ifid_instr  <= 14'(0);
            ifid_valid  <= 1'b0;
            id_valid    <= 1'b0;
            id_opcode   <= OP_NOP;
            id_vd       <= 2'(0);
            id_vs1_data <= VEC_W'(0);
            id_vs2_data <= VEC_W'(0);
            id_imm      <= 4'(0);
            id_we       <= 1'b0;
            for (int i = 0; i < NUM_VREG; i++) begin
                vreg[i] <= VEC_W'(0);
            end
        end else begin
            if (wb_we) begin
                vreg[wb_addr] <= wb_data;
            end

            if (state == RUN) begin
                if (flush) begin
                    ifid_valid <= 1'b0;
                end else if (!hazard) begin
                    ifid_instr <= instruccion;
                    ifid_valid <= 1'b1;
                end
            end

            // Non-issuing cycles present a fully cleared bubble
            id_valid    <= issue;
            id_opcode   <= issue ? dec_op : OP_NOP;
            id_vd       <= issue ? f_vd : 2'(0);
            id_vs1_data <= issue ? rd1 : VEC_W'(0);
            id_vs2_data <= issue ? rd2 : VEC_W'(0);
            id_imm      <= issue ? f_imm : 4'(0);
            id_we       <= issue && dec_we;

            if (issue && (f_op == OP_HALT)) begin
                state <= HALTED;
            end
        end
    end

endmodule
